fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundles the fetch queue's memory request/response port and its decode handshake.
// master: the fetch queue itself; slave: the memory and decoder side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [63:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             redirect;
  logic [63:0]      redirect_pc;
  logic             stop;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [63:0]      instr_pc;
  logic             instr_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc, stop,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc, stop,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch: one outstanding memory read, a small PC-tagged FIFO
// toward decode, and redirect handling that flushes and squashes stale data.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           r_state;
  logic [63:0]      r_fetch_pc;
  logic [31:0]      r_data [DEPTH];
  logic [63:0]      r_pc   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_req;
  logic w_accept;
  logic w_push;
  logic w_valid;
  logic w_pop;

  // Issue only with a free slot, so the eventual push can never overflow.
  assign w_req    = (r_state == S_FETCH) && (r_count < CNT_W'(DEPTH)) &&
                    !fq.stop && !fq.redirect && !reset;
  assign w_accept = w_req && fq.imem_gnt;
  assign w_push   = (r_state == S_WAIT) && fq.imem_rvalid && !fq.redirect && !reset;
  assign w_valid  = (r_count != '0) && !fq.redirect && !reset;
  assign w_pop    = w_valid && fq.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (fq.redirect) begin
      // Flush; an in-flight request leaves exactly one response to drop.
      r_fetch_pc <= fq.redirect_pc & ~64'h3;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      case (r_state)
        S_WAIT, S_DISCARD: r_state <= fq.imem_rvalid ? S_FETCH : S_DISCARD;
        default:           r_state <= S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            r_state    <= S_WAIT;
            r_fetch_pc <= r_fetch_pc + 64'd4;
          end
        end
        S_WAIT, S_DISCARD: begin
          if (fq.imem_rvalid) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // fetch_pc has already advanced past the outstanding request.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= fq.imem_rdata;
      r_pc[r_tail]   <= r_fetch_pc - 64'd4;
    end
  end

  assign fq.imem_req    = w_req;
  assign fq.imem_addr   = r_fetch_pc;
  assign fq.instr_valid = w_valid;
  assign fq.instr       = r_data[r_head];
  assign fq.instr_pc    = r_pc[r_head];
  assign fq.count       = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, pop, push/pop overlap, redirect squash,
// stop and mid-stream reset, each against hand-derived expected values.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h2000)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  function automatic logic [31:0] dat(input logic [63:0] a);
    return 32'hC0DE_0000 | 32'(a[15:0]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; checks follow 1ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_one(input string tag, input logic [63:0] a);
    #1;
    chk({tag, " req"},  64'(fq.imem_req), 64'd1);
    chk({tag, " addr"}, fq.imem_addr, a);
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = dat(a);
    #1;
    chk({tag, " wait req"}, 64'(fq.imem_req), 64'd0);
    step();
    fq.imem_rvalid = 1'b0;
    fq.imem_rdata  = '0;
  endtask

  initial begin
    reset          = 1'b1;
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b0;
    fq.imem_rdata  = '0;
    fq.redirect    = 1'b0;
    fq.redirect_pc = '0;
    fq.stop        = 1'b0;
    fq.instr_ready = 1'b0;

    #3;
    chk("rst req",   64'(fq.imem_req),    64'd0);
    chk("rst valid", 64'(fq.instr_valid), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post rst count", 64'(fq.count),       64'd0);
    chk("post rst addr",  fq.imem_addr,        64'h2000);
    chk("post rst req",   64'(fq.imem_req),    64'd1);
    chk("post rst valid", 64'(fq.instr_valid), 64'd0);

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) fetch_one("fill", 64'h2000 + 64'(4 * i));
    #1;
    chk("full count", 64'(fq.count),       64'd4);
    chk("full req",   64'(fq.imem_req),    64'd0);
    chk("full valid", 64'(fq.instr_valid), 64'd1);
    chk("full pc",    fq.instr_pc,         64'h2000);
    chk("full instr", 64'(fq.instr),       64'(dat(64'h2000)));

    // Single pop reopens fetch.
    fq.instr_ready = 1'b1;
    step();
    fq.instr_ready = 1'b0;
    #1;
    chk("pop count", 64'(fq.count),    64'd3);
    chk("pop req",   64'(fq.imem_req), 64'd1);
    chk("pop addr",  fq.imem_addr,     64'h2010);
    chk("pop head",  fq.instr_pc,      64'h2004);

    // Push and pop in the same cycle.
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = dat(64'h2010);
    fq.instr_ready = 1'b1;
    #1;
    chk("pp head before", fq.instr_pc, 64'h2004);
    step();
    fq.imem_rvalid = 1'b0;
    fq.instr_ready = 1'b0;
    #1;
    chk("pp count", 64'(fq.count), 64'd3);
    chk("pp head",  fq.instr_pc,   64'h2008);

    // Drain in order.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain pc",    fq.instr_pc,   64'h2008 + 64'(4 * i));
      chk("drain instr", 64'(fq.instr), 64'(dat(64'h2008 + 64'(4 * i))));
      fq.instr_ready = 1'b1;
      step();
      fq.instr_ready = 1'b0;
    end
    #1;
    chk("empty count", 64'(fq.count),       64'd0);
    chk("empty valid", 64'(fq.instr_valid), 64'd0);

    // Push into an empty queue is not bypassed to decode.
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = dat(64'h2014);
    fq.instr_ready = 1'b1;
    #1;
    chk("nobypass valid", 64'(fq.instr_valid), 64'd0);
    step();
    fq.imem_rvalid = 1'b0;
    fq.instr_ready = 1'b0;
    #1;
    chk("nobypass count", 64'(fq.count),       64'd1);
    chk("nobypass vld2",  64'(fq.instr_valid), 64'd1);
    chk("nobypass pc",    fq.instr_pc,         64'h2014);

    // Redirect while WAIT, response arrives later and is dropped.
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.redirect    = 1'b1;
    fq.redirect_pc = 64'h3002;
    #1;
    chk("redir valid", 64'(fq.instr_valid), 64'd0);
    chk("redir req",   64'(fq.imem_req),    64'd0);
    step();
    fq.redirect = 1'b0;
    #1;
    chk("discard count", 64'(fq.count),    64'd0);
    chk("discard req",   64'(fq.imem_req), 64'd0);
    chk("discard addr",  fq.imem_addr,     64'h3000);
    step();
    #1;
    chk("discard req2", 64'(fq.imem_req), 64'd0);
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = 32'hDEAD_BEEF;
    step();
    fq.imem_rvalid = 1'b0;
    #1;
    chk("dropped count", 64'(fq.count),    64'd0);
    chk("refetch req",   64'(fq.imem_req), 64'd1);
    fetch_one("target", 64'h3000);
    #1;
    chk("target count", 64'(fq.count),   64'd1);
    chk("target pc",    fq.instr_pc,     64'h3000);
    chk("target instr", 64'(fq.instr),   64'(dat(64'h3000)));

    // Redirect coincident with the response in WAIT.
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = dat(64'h3004);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 64'h4000;
    step();
    fq.imem_rvalid = 1'b0;
    fq.redirect    = 1'b0;
    #1;
    chk("redir+rv count", 64'(fq.count),    64'd0);
    chk("redir+rv req",   64'(fq.imem_req), 64'd1);
    chk("redir+rv addr",  fq.imem_addr,     64'h4000);

    // stop during WAIT: response still pushed, then no new requests.
    fq.imem_gnt = 1'b1;
    step();
    fq.imem_gnt    = 1'b0;
    fq.stop        = 1'b1;
    fq.imem_rvalid = 1'b1;
    fq.imem_rdata  = dat(64'h4000);
    step();
    fq.imem_rvalid = 1'b0;
    #1;
    chk("stop req",   64'(fq.imem_req), 64'd0);
    chk("stop count", 64'(fq.count),    64'd1);
    chk("stop pc",    fq.instr_pc,      64'h4000);
    step();
    #1;
    chk("stop req2", 64'(fq.imem_req), 64'd0);
    chk("stop addr", fq.imem_addr,     64'h4004);
    fq.stop = 1'b0;
    #1;
    chk("resume req", 64'(fq.imem_req), 64'd1);

    // Reset mid-stream with three entries queued.
    fetch_one("pre rst", 64'h4004);
    fetch_one("pre rst", 64'h4008);
    #1;
    chk("pre rst count", 64'(fq.count), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid rst req",   64'(fq.imem_req),    64'd0);
    chk("mid rst valid", 64'(fq.instr_valid), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("after rst count", 64'(fq.count),       64'd0);
    chk("after rst valid", 64'(fq.instr_valid), 64'd0);
    chk("after rst addr",  fq.imem_addr,        64'h2000);
    chk("after rst req",   64'(fq.imem_req),    64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
